// File: rtl/corr_pkg.sv
// corr_pkg: shared definitions for the correlation window engine.
//   - corrState_t : engine FSM states (IDLE, FETCH, DRAIN, DONE)
//   - CORR_W / COORD_W / FADDR_W / TADDR_W : result, coordinate, frame and
//     template address widths
//   - H_RES / V_RES : frame geometry (mirrors the capture parameter set)
//   - satAdd  : unsigned add that clamps at all-ones
//   - inFrame : true when a (column,row) pixel position lies inside the frame
package corr_pkg;

  localparam int CORR_W  = 32;
  localparam int COORD_W = 13;
  localparam int FADDR_W = 23;
  localparam int TADDR_W = 12;
  // Pixel positions carry one extra bit so origin + template offset never wraps.
  localparam int POS_W   = COORD_W + 1;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } corrState_t;

  function automatic logic [CORR_W-1:0] satAdd(input logic [CORR_W-1:0] a,
                                               input logic [CORR_W-1:0] b);
    logic [CORR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CORR_W]) begin
      satAdd = {CORR_W{1'b1}};
    end else begin
      satAdd = sum[CORR_W-1:0];
    end
  endfunction

  function automatic logic inFrame(input logic [POS_W-1:0] col,
                                   input logic [POS_W-1:0] row);
    inFrame = (col < POS_W'(H_RES)) && (row < POS_W'(V_RES));
  endfunction

endpackage

// File: rtl/corr_mac_pipe.sv
// corr_mac_pipe: multiply-accumulate back end of the correlation engine.
//   Delays the per-slot valid and live (in-frame) flags by RD_LAT cycles so
//   they line up with the memory read data, forms the pixel product (forced to
//   zero for out-of-frame slots) and accumulates it into a 32-bit sum.
//   Build option: CORR_SATURATE_EN defined -> accumulator clamps at
//   32'hFFFF_FFFF; undefined -> accumulator wraps modulo 2^32.
// Ports:
//   iCLK, iRST_N      clock, async active-low reset
//   iClear            clears the accumulator (window accepted)
//   iSlotValid        an address slot was issued this cycle
//   iSlotLive         that slot lies inside the frame
//   iFramePix/iTplPix memory read data, RD_LAT cycles after the slot
//   oAcc              running correlation sum
module corr_mac_pipe
  import corr_pkg::*;
#(
  parameter int PIX_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iClear,
  input  logic              iSlotValid,
  input  logic              iSlotLive,
  input  logic [PIX_W-1:0]  iFramePix,
  input  logic [PIX_W-1:0]  iTplPix,
  output logic [CORR_W-1:0] oAcc
);

  localparam int PROD_W = 2 * PIX_W;

  logic [RD_LAT-1:0] validDlyR;
  logic [RD_LAT-1:0] liveDlyR;
  logic [PROD_W-1:0] prodR;
  logic              prodValidR;
  logic [CORR_W-1:0] accR;
  logic [CORR_W-1:0] addend;
  logic [CORR_W-1:0] accNx;

  // Flag delay line matching the memory read latency.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      validDlyR <= {RD_LAT{1'b0}};
      liveDlyR  <= {RD_LAT{1'b0}};
    end else begin
      validDlyR[0] <= iSlotValid;
      liveDlyR[0]  <= iSlotLive;
      for (int k = 1; k < RD_LAT; k++) begin
        validDlyR[k] <= validDlyR[k-1];
        liveDlyR[k]  <= liveDlyR[k-1];
      end
    end
  end

  // Product stage; out-of-frame read data is garbage, so it is masked to zero.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prodR      <= {PROD_W{1'b0}};
      prodValidR <= 1'b0;
    end else begin
      prodValidR <= validDlyR[RD_LAT-1];
      if (liveDlyR[RD_LAT-1]) begin
        prodR <= {{PIX_W{1'b0}}, iFramePix} * {{PIX_W{1'b0}}, iTplPix};
      end else begin
        prodR <= {PROD_W{1'b0}};
      end
    end
  end

  // Product widened to the accumulator width.
  always_comb begin
    addend = CORR_W'(prodR);
  end

`ifdef CORR_SATURATE_EN
  // Clamping add: once at all-ones the sum stays there until the next clear.
  always_comb begin
    accNx = satAdd(accR, addend);
  end
`else
  // Wrapping add, modulo 2^32.
  always_comb begin
    accNx = accR + addend;
  end
`endif

  // Accumulator register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      accR <= {CORR_W{1'b0}};
    end else if (iClear) begin
      accR <= {CORR_W{1'b0}};
    end else if (prodValidR) begin
      accR <= accNx;
    end else begin
      accR <= accR;
    end
  end

  assign oAcc = accR;

endmodule

// File: rtl/corr_window_engine.sv
// corr_window_engine: computes sum(frame(X+i,Y+j) * tpl(i,j)) over a
//   TPL_W x TPL_H window for the coordinate-search controller.
//   FSM IDLE -> FETCH -> DRAIN -> DONE; one address slot per FETCH cycle,
//   accept-to-pulse latency TPL_W*TPL_H + RD_LAT + 2 cycles.
//   Build option: CORR_SATURATE_EN (see corr_mac_pipe).
// Ports:
//   iCLK, iRST_N    clock, async active-low reset
//   iStart, iX, iY  start request and window origin, taken only in IDLE
//   oBusy           high from the cycle after accept until the result pulse
//   oFrameRdEn      frame read strobe (low for out-of-frame slots)
//   oFrameAddr      frame address (Y+j)*H_RES + (X+i)
//   iFramePix       frame read data, RD_LAT cycles after the address
//   oTplAddr        template address j*TPL_W + i
//   iTplPix         template read data, RD_LAT cycles after the address
//   oCorrFinished   one-cycle result pulse
//   oCurrentCorr    result, held until the next pulse
module corr_window_engine
  import corr_pkg::*;
#(
  parameter int TPL_W  = 8,
  parameter int TPL_H  = 8,
  parameter int PIX_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  output logic               oBusy,
  output logic               oFrameRdEn,
  output logic [FADDR_W-1:0] oFrameAddr,
  input  logic [PIX_W-1:0]   iFramePix,
  output logic [TADDR_W-1:0] oTplAddr,
  input  logic [PIX_W-1:0]   iTplPix,
  output logic               oCorrFinished,
  output logic [CORR_W-1:0]  oCurrentCorr
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0]   I_LAST    = CNT_W'(TPL_W - 1);
  localparam logic [CNT_W-1:0]   J_LAST    = CNT_W'(TPL_H - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
  localparam logic [TADDR_W-1:0] TADDR_ONE = TADDR_W'(1);
  localparam logic [FADDR_W-1:0] FADDR_ONE = FADDR_W'(1);
  localparam logic [FADDR_W-1:0] H_RES_F   = FADDR_W'(H_RES);
  // Moving from the last column of one row to the first of the next.
  localparam logic [FADDR_W-1:0] ROW_STEP  = FADDR_W'(H_RES - TPL_W + 1);
  localparam logic [1:0]         DRAIN_END = 2'(RD_LAT);

  corrState_t         stateR;
  corrState_t         stateNx;
  logic               accept;
  logic               lastSlot;
  logic               drainEnd;
  logic [1:0]         drainCntR;

  logic [CNT_W-1:0]   iCntR;
  logic [CNT_W-1:0]   jCntR;
  logic [POS_W-1:0]   xOrgR;
  logic [POS_W-1:0]   colR;
  logic [POS_W-1:0]   rowR;
  logic [FADDR_W-1:0] frameAddrR;
  logic [TADDR_W-1:0] tplAddrR;
  logic               slotValidR;
  logic               rdEnR;

  logic               busyR;
  logic               finishedR;
  logic [CORR_W-1:0]  corrR;
  logic [CORR_W-1:0]  acc;

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNx;
    end
  end

  // FSM next-state and accept decode.
  always_comb begin
    stateNx  = stateR;
    accept   = 1'b0;
    lastSlot = (iCntR == I_LAST) && (jCntR == J_LAST);
    drainEnd = (drainCntR == DRAIN_END);
    case (stateR)
      IDLE: begin
        if (iStart) begin
          accept  = 1'b1;
          stateNx = FETCH;
        end else begin
          stateNx = IDLE;
        end
      end
      FETCH: begin
        if (lastSlot) begin
          stateNx = DRAIN;
        end else begin
          stateNx = FETCH;
        end
      end
      DRAIN: begin
        if (drainEnd) begin
          stateNx = DONE;
        end else begin
          stateNx = DRAIN;
        end
      end
      DONE: begin
        stateNx = IDLE;
      end
      default: begin
        stateNx = IDLE;
      end
    endcase
  end

  // Drain counter: DRAIN lasts RD_LAT+1 cycles so the MAC pipeline empties.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      drainCntR <= 2'd0;
    end else if (stateR == DRAIN) begin
      drainCntR <= drainCntR + 2'd1;
    end else begin
      drainCntR <= 2'd0;
    end
  end

  // Address generator: registers hold the slot currently on the memory ports.
  // The origin product Y*H_RES uses a constant coefficient and is formed once
  // per window; per-slot addresses are built only with increments.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      iCntR      <= {CNT_W{1'b0}};
      jCntR      <= {CNT_W{1'b0}};
      xOrgR      <= {POS_W{1'b0}};
      colR       <= {POS_W{1'b0}};
      rowR       <= {POS_W{1'b0}};
      frameAddrR <= {FADDR_W{1'b0}};
      tplAddrR   <= {TADDR_W{1'b0}};
      slotValidR <= 1'b0;
      rdEnR      <= 1'b0;
    end else if (accept) begin
      iCntR      <= {CNT_W{1'b0}};
      jCntR      <= {CNT_W{1'b0}};
      xOrgR      <= {1'b0, iX};
      colR       <= {1'b0, iX};
      rowR       <= {1'b0, iY};
      frameAddrR <= FADDR_W'(iY) * H_RES_F + FADDR_W'(iX);
      tplAddrR   <= {TADDR_W{1'b0}};
      slotValidR <= 1'b1;
      rdEnR      <= inFrame({1'b0, iX}, {1'b0, iY});
    end else if ((stateR == FETCH) && !lastSlot) begin
      tplAddrR <= tplAddrR + TADDR_ONE;
      if (iCntR == I_LAST) begin
        iCntR      <= {CNT_W{1'b0}};
        jCntR      <= jCntR + CNT_ONE;
        colR       <= xOrgR;
        rowR       <= rowR + POS_ONE;
        frameAddrR <= frameAddrR + ROW_STEP;
        rdEnR      <= inFrame(xOrgR, rowR + POS_ONE);
      end else begin
        iCntR      <= iCntR + CNT_ONE;
        colR       <= colR + POS_ONE;
        frameAddrR <= frameAddrR + FADDR_ONE;
        rdEnR      <= inFrame(colR + POS_ONE, rowR);
      end
    end else begin
      slotValidR <= 1'b0;
      rdEnR      <= 1'b0;
    end
  end

  corr_mac_pipe #(
    .PIX_W (PIX_W),
    .RD_LAT(RD_LAT)
  ) uMacPipe (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iClear    (accept),
    .iSlotValid(slotValidR),
    .iSlotLive (rdEnR),
    .iFramePix (iFramePix),
    .iTplPix   (iTplPix),
    .oAcc      (acc)
  );

  // Registered status and result outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busyR     <= 1'b0;
      finishedR <= 1'b0;
      corrR     <= {CORR_W{1'b0}};
    end else begin
      busyR     <= (stateNx != IDLE);
      finishedR <= (stateR == DONE);
      if (stateR == DONE) begin
        corrR <= acc;
      end else begin
        corrR <= corrR;
      end
    end
  end

  assign oBusy         = busyR;
  assign oFrameRdEn    = rdEnR;
  assign oFrameAddr    = frameAddrR;
  assign oTplAddr      = tplAddrR;
  assign oCorrFinished = finishedR;
  assign oCurrentCorr  = corrR;

endmodule

// File: tb/tb_corr_window_engine.sv
// tb_corr_window_engine: self-checking bench for corr_window_engine.
//   Two instances: A (8x8, RD_LAT=1) and B (64x64, RD_LAT=2) share behavioural
//   frame/template memories. Results are compared with a reference that sums
//   frame*template products directly over the window.
module tb_corr_window_engine;
  import corr_pkg::*;

  localparam int AW = 8;
  localparam int AH = 8;
  localparam int ALAT = 1;
  localparam int AN = AW * AH;
  localparam int ALATENCY = AN + ALAT + 2;
  localparam int BW = 64;
  localparam int BH = 64;
  localparam int BLAT = 2;
  localparam int BLATENCY = BW * BH + BLAT + 2;
  localparam int FSIZE = H_RES * V_RES;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  logic iRST_N;

  logic        startA, busyA, frEnA, finA;
  logic [12:0] xA, yA;
  logic [22:0] frAddrA;
  logic [11:0] tpAddrA, framePixA, tplPixA;
  logic [31:0] corrA;

  logic        startB, busyB, frEnB, finB;
  logic [12:0] xB, yB;
  logic [22:0] frAddrB;
  logic [11:0] tpAddrB, framePixB, tplPixB;
  logic [31:0] corrB;

  logic [11:0] frameMem [FSIZE];
  logic [11:0] tplMem [4096];

  int testCnt = 0;
  int failCnt = 0;

  corr_window_engine #(.TPL_W(AW), .TPL_H(AH), .PIX_W(12), .RD_LAT(ALAT)) dutA (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(startA), .iX(xA), .iY(yA),
    .oBusy(busyA), .oFrameRdEn(frEnA), .oFrameAddr(frAddrA), .iFramePix(framePixA),
    .oTplAddr(tpAddrA), .iTplPix(tplPixA), .oCorrFinished(finA), .oCurrentCorr(corrA));

  corr_window_engine #(.TPL_W(BW), .TPL_H(BH), .PIX_W(12), .RD_LAT(BLAT)) dutB (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(startB), .iX(xB), .iY(yB),
    .oBusy(busyB), .oFrameRdEn(frEnB), .oFrameAddr(frAddrB), .iFramePix(framePixB),
    .oTplAddr(tpAddrB), .iTplPix(tplPixB), .oCorrFinished(finB), .oCurrentCorr(corrB));

  // Frame read: garbage unless strobed, so the DUT must mask unread slots.
  function automatic logic [11:0] readFrame(input logic en, input logic [22:0] a);
    if (en && (int'(a) < FSIZE)) return frameMem[int'(a)];
    return 12'($urandom);
  endfunction

  logic [11:0] fqA [ALAT];
  logic [11:0] tqA [ALAT];
  logic [11:0] fqB [BLAT];
  logic [11:0] tqB [BLAT];

  always @(posedge iCLK) begin
    fqA[0] <= readFrame(frEnA, frAddrA);
    tqA[0] <= tplMem[tpAddrA];
    for (int k = 1; k < ALAT; k++) begin
      fqA[k] <= fqA[k-1];
      tqA[k] <= tqA[k-1];
    end
    fqB[0] <= readFrame(frEnB, frAddrB);
    tqB[0] <= tplMem[tpAddrB];
    for (int k = 1; k < BLAT; k++) begin
      fqB[k] <= fqB[k-1];
      tqB[k] <= tqB[k-1];
    end
  end
  assign framePixA = fqA[ALAT-1];
  assign tplPixA   = tqA[ALAT-1];
  assign framePixB = fqB[BLAT-1];
  assign tplPixB   = tqB[BLAT-1];

  // Reference correlation: direct sum over in-frame pixels.
  function automatic logic [31:0] refCorr(input int x, input int y, input int w, input int h);
    longint sum = 0;
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        if ((x + i) < H_RES && (y + j) < V_RES)
          sum += longint'(frameMem[(y + j) * H_RES + x + i]) * longint'(tplMem[j * w + i]);
      end
    end
`ifdef CORR_SATURATE_EN
    if (sum > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return sum[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fillFrame(input int mode, input int v);
    for (int k = 0; k < FSIZE; k++) frameMem[k] = (mode == 0) ? 12'(v) : 12'($urandom);
  endtask

  task automatic fillTpl(input int mode, input int v);
    for (int k = 0; k < 4096; k++) tplMem[k] = (mode == 0) ? 12'(v) : 12'($urandom_range(4095, 1));
  endtask

  task automatic checkSlot(input int x, input int y, input int c);
    int col, row;
    bit inF;
    col = x + c % AW;
    row = y + c / AW;
    inF = (col < H_RES) && (row < V_RES);
    check("tpl_addr", tpAddrA, c);
    check("frame_rd_en", frEnA, inF);
    if (inF) check("frame_addr", frAddrA, row * H_RES + col);
  endtask

  // Runs one window on instance A from a negedge; returns at the pulse negedge.
  task automatic doWindowA(input int x, input int y, input bit keepStart,
                           output longint pulseTime, output logic [31:0] res);
    logic [31:0] exp;
    int c;
    bit seen;
    exp = refCorr(x, y, AW, AH);
    startA = 1'b1;
    xA = 13'(x);
    yA = 13'(y);
    @(posedge iCLK);
    @(negedge iCLK);
    if (!keepStart) startA = 1'b0;
    check("busy_after_accept", busyA, 1'b1);
    seen = 1'b0;
    pulseTime = 0;
    res = 32'd0;
    c = 0;
    while (!seen && c <= ALATENCY + 4) begin
      if (c < AN) checkSlot(x, y, c);
      if (keepStart) begin
        xA = 13'($urandom);
        yA = 13'($urandom);
      end
      if (finA) begin
        seen = 1'b1;
        pulseTime = $time;
        res = corrA;
        check("latency", c, ALATENCY);
        check("result", corrA, exp);
        check("busy_at_pulse", busyA, 1'b0);
      end else begin
        @(negedge iCLK);
        c++;
      end
    end
    check("pulse_seen", seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t1, t2;
    logic [31:0] res, best;
    int bestX, bestY, pulses, x, y;

    iRST_N = 1'b0;
    startA = 1'b0; xA = 13'd0; yA = 13'd0;
    startB = 1'b0; xB = 13'd0; yB = 13'd0;
    fillFrame(0, 0);
    fillTpl(0, 0);
    repeat (3) @(negedge iCLK);
    check("rst_busyA", busyA, 1'b0);
    check("rst_rdenA", frEnA, 1'b0);
    check("rst_faddrA", frAddrA, 23'd0);
    check("rst_taddrA", tpAddrA, 12'd0);
    check("rst_finA", finA, 1'b0);
    check("rst_corrA", corrA, 32'd0);
    check("rst_finB", finB, 1'b0);
    check("rst_corrB", corrB, 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // 1: all-1 template, all-2 frame at origin.
    fillFrame(0, 2);
    fillTpl(0, 1);
    doWindowA(0, 0, 1'b0, t0, res);
    check("t1_const", res, 32'd128);
    @(negedge iCLK);
    check("t1_pulse_width", finA, 1'b0);
    check("t1_hold", corrA, 32'd128);

    // 2: corner window, only 4x2 pixels in frame.
    fillFrame(0, 1);
    fillTpl(0, 1);
    repeat (2) @(negedge iCLK);
    doWindowA(H_RES - 4, V_RES - 2, 1'b0, t0, res);
    check("t2_const", res, 32'd8);

    // 3: iStart held across three windows, origin jitter ignored.
    fillFrame(1, 0);
    fillTpl(1, 0);
    @(negedge iCLK);
    doWindowA(100, 50, 1'b1, t0, res);
    doWindowA(300, 200, 1'b1, t1, res);
    doWindowA(H_RES - 3, 10, 1'b0, t2, res);
    check("t3_spacing1", t1 - t0, 64'(10 * (ALATENCY + 1)));
    check("t3_spacing2", t2 - t1, 64'(10 * (ALATENCY + 1)));
    @(negedge iCLK);
    check("t3_no_restart", busyA, 1'b0);

    // 4: reset in the middle of a window.
    startA = 1'b1; xA = 13'd20; yA = 13'd30;
    @(posedge iCLK);
    @(negedge iCLK);
    startA = 1'b0;
    repeat (20) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check("t4_busy", busyA, 1'b0);
    check("t4_rden", frEnA, 1'b0);
    check("t4_faddr", frAddrA, 23'd0);
    check("t4_taddr", tpAddrA, 12'd0);
    check("t4_fin", finA, 1'b0);
    check("t4_corr", corrA, 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    pulses = 0;
    for (int k = 0; k < ALATENCY + 5; k++) begin
      @(negedge iCLK);
      if (finA) pulses++;
    end
    check("t4_no_pulse", pulses, 0);
    doWindowA(20, 30, 1'b0, t0, res);

    // 5: 64x64 all-4095 on instance B (overflow / saturation).
    fillFrame(0, 4095);
    fillTpl(0, 4095);
    @(negedge iCLK);
    startB = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    startB = 1'b0;
    pulses = 0;
    for (int k = 0; k <= BLATENCY + 4 && pulses == 0; k++) begin
      if (finB) begin
        pulses = 1;
        check("t5_latency", k, BLATENCY);
        check("t5_model", corrB, refCorr(0, 0, BW, BH));
`ifdef CORR_SATURATE_EN
        check("t5_const", corrB, 32'hFFFF_FFFF);
`else
        check("t5_const", corrB, 32'hFE00_1000);
`endif
      end else begin
        @(negedge iCLK);
      end
    end
    check("t5_pulse_seen", pulses, 1);

    // 6: template planted at (5,3); sweep must peak there.
    fillFrame(0, 0);
    fillTpl(1, 0);
    for (int j = 0; j < AH; j++)
      for (int i = 0; i < AW; i++)
        frameMem[(3 + j) * H_RES + 5 + i] = tplMem[j * AW + i];
    best = 32'd0; bestX = -1; bestY = -1;
    for (int sy = 1; sy <= 5; sy++) begin
      for (int sx = 3; sx <= 7; sx++) begin
        @(negedge iCLK);
        doWindowA(sx, sy, 1'b0, t0, res);
        if (res > best) begin
          best = res; bestX = sx; bestY = sy;
        end
      end
    end
    check("t6_peak_x", bestX, 5);
    check("t6_peak_y", bestY, 3);

    // 7: random data, random origins biased toward the frame edges.
    fillFrame(1, 0);
    fillTpl(1, 0);
    for (int k = 0; k < 6; k++) begin
      x = (k % 2 == 1) ? int'($urandom_range(H_RES + 2, H_RES - 10)) : int'($urandom_range(H_RES - 1, 0));
      y = (k % 3 == 2) ? int'($urandom_range(V_RES + 2, V_RES - 10)) : int'($urandom_range(V_RES - 1, 0));
      @(negedge iCLK);
      doWindowA(x, y, 1'b0, t0, res);
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
